// File: rtl/sd_wrr_pktmux.sv
// sd_wrr_pktmux
// Weighted round-robin, packet-aware arbiter sharing one srdy/drdy output
// channel among `inputs` srdy/drdy producers. A granted input owns the
// channel until the end of its packet and keeps it for up to cfg_weight
// packets (0 treated as 1) before ownership rotates.
//
// Ports:
//   clk, reset       rising-edge clock, synchronous active-high reset
//   c_srdy/c_drdy    per-input handshake
//   c_data/c_eop     per-input word and end-of-packet (input i at [i*width +: width])
//   cfg_weight       per-input packets-per-grant, sampled at grant time
//   p_srdy/p_drdy    registered output handshake (one-entry output register)
//   p_data/p_eop     registered output word and end-of-packet
//   p_grant          one-hot owner while a packet stream is owned, else 0
module sd_wrr_pktmux #(
  parameter int width    = 16,
  parameter int inputs   = 4,
  parameter int wt_width = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [inputs-1:0]          c_srdy,
  output logic [inputs-1:0]          c_drdy,
  input  logic [inputs*width-1:0]    c_data,
  input  logic [inputs-1:0]          c_eop,
  input  logic [inputs*wt_width-1:0] cfg_weight,
  output logic                       p_srdy,
  input  logic                       p_drdy,
  output logic [width-1:0]           p_data,
  output logic                       p_eop,
  output logic [inputs-1:0]          p_grant
);

  localparam int          iw   = $clog2(inputs);
  localparam int unsigned n_in = inputs;

  localparam logic [0:0] s_idle = 1'b0;
  localparam logic [0:0] s_own  = 1'b1;

  logic [0:0]          state;
  logic [iw-1:0]       ptr;
  logic [iw-1:0]       owner;
  logic [wt_width-1:0] credit;
  logic                boundary;   // last owner word transferred was an eop

  logic [iw-1:0]       winner;
  logic                win_found;
  logic [iw:0]         cand;
  logic [iw-1:0]       sel_idx;
  logic [inputs-1:0]   sel;
  logic [inputs-1:0]   owner_oh;
  logic [inputs-1:0]   win_oh;
  logic                accept;
  logic                load;
  logic [width-1:0]    load_data;
  logic                load_eop;
  logic [wt_width-1:0] win_wt;
  logic [wt_width-1:0] wload;
  logic [wt_width-1:0] credit_dec;
  logic                release_own;

  function automatic logic [iw-1:0] next_idx(input logic [iw-1:0] i);
    return (i == iw'(n_in - 1)) ? '0 : i + iw'(1);
  endfunction

  // First requester in search order ptr, ptr+1, ... modulo inputs.
  always_comb begin
    winner    = '0;
    win_found = 1'b0;
    cand      = '0;
    for (int unsigned k = 0; k < n_in; k++) begin
      cand = {1'b0, ptr} + (iw+1)'(k);
      if (cand >= (iw+1)'(n_in)) cand = cand - (iw+1)'(n_in);
      if (!win_found && c_srdy[cand[iw-1:0]]) begin
        win_found = 1'b1;
        winner    = cand[iw-1:0];
      end
    end
  end

  always_comb begin
    owner_oh        = '0;
    owner_oh[owner] = 1'b1;
    win_oh          = '0;
    win_oh[winner]  = win_found;
  end

  assign sel_idx    = (state == s_own) ? owner : winner;
  assign sel        = (state == s_own) ? owner_oh : win_oh;
  assign accept     = ~p_srdy | p_drdy;
  assign c_drdy     = reset ? '0 : (sel & {inputs{accept}});
  assign load       = |(c_srdy & c_drdy);
  assign load_data  = c_data[sel_idx*width +: width];
  assign load_eop   = c_eop[sel_idx];
  assign win_wt     = cfg_weight[winner*wt_width +: wt_width];
  assign wload      = (win_wt == '0) ? wt_width'(1) : win_wt;
  assign credit_dec = credit - wt_width'(1);
  assign p_grant    = (state == s_own) ? owner_oh : '0;

  // Give up remaining credit when the owner is idle between packets and
  // someone else is waiting; the owner never blocks the channel at a boundary.
  assign release_own = boundary & ~c_srdy[owner] & (|(c_srdy & ~owner_oh));

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= s_idle;
      ptr      <= '0;
      owner    <= '0;
      credit   <= '0;
      boundary <= 1'b0;
    end else if (state == s_idle) begin
      if (load) begin
        // A single-word packet that also exhausts its grant never enters OWN.
        if (load_eop && (wload == wt_width'(1))) begin
          ptr <= next_idx(winner);
        end else begin
          state    <= s_own;
          owner    <= winner;
          credit   <= load_eop ? wload - wt_width'(1) : wload;
          boundary <= load_eop;
        end
      end
    end else begin
      if (load) begin
        if (load_eop) begin
          credit   <= credit_dec;
          boundary <= 1'b1;
          if (credit_dec == '0) begin
            state <= s_idle;
            ptr   <= next_idx(owner);
          end
        end else begin
          boundary <= 1'b0;
        end
      end else if (release_own) begin
        state <= s_idle;
        ptr   <= next_idx(owner);
      end
    end
  end

  // One-entry output register.
  always_ff @(posedge clk) begin
    if (reset) begin
      p_srdy <= 1'b0;
      p_data <= '0;
      p_eop  <= 1'b0;
    end else if (load) begin
      p_srdy <= 1'b1;
      p_data <= load_data;
      p_eop  <= load_eop;
    end else if (p_drdy) begin
      p_srdy <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sd_wrr_pktmux.sv
// tb_sd_wrr_pktmux
// Directed bench for sd_wrr_pktmux (4 inputs, 16-bit data, 4-bit weights).
// Per-input word tables feed the DUT; output words are logged and compared
// against hand-derived sequences. Words are tagged {eop, src[3:0], seq[11:0]}.
module tb_sd_wrr_pktmux;

  localparam int W  = 16;
  localparam int N  = 4;
  localparam int WW = 4;

  logic           clk = 1'b0;
  logic           reset;
  logic [N-1:0]   c_srdy;
  logic [N-1:0]   c_drdy;
  logic [N*W-1:0] c_data;
  logic [N-1:0]   c_eop;
  logic [N*WW-1:0] cfg_weight;
  logic           p_srdy;
  logic           p_drdy;
  logic [W-1:0]   p_data;
  logic           p_eop;
  logic [N-1:0]   p_grant;

  sd_wrr_pktmux #(.width(W), .inputs(N), .wt_width(WW)) dut (
    .clk(clk), .reset(reset),
    .c_srdy(c_srdy), .c_drdy(c_drdy), .c_data(c_data), .c_eop(c_eop),
    .cfg_weight(cfg_weight),
    .p_srdy(p_srdy), .p_drdy(p_drdy), .p_data(p_data), .p_eop(p_eop),
    .p_grant(p_grant)
  );

  always #5 clk = ~clk;

  int unsigned total = 0;
  int unsigned bad   = 0;

  logic [16:0]  mem [N][64];
  int unsigned  cnt [N];
  int unsigned  rd  [N];
  logic [N-1:0] en;
  logic         rnd_drdy;
  logic [16:0]  outq[$];
  int unsigned  outcyc[$];
  int unsigned  cyc = 0;
  logic [N-1:0] s_drdy;
  logic [N-1:0] s_grant;
  logic         s_psrdy;
  logic         hold_v;
  logic [31:0]  hold_val;
  int           order [12] = '{0, 0, 0, 1, 2, 3, 0, 0, 0, 1, 2, 3};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [16:0] tagw(input int s, input int q, input bit e);
    return {e, 4'(s), 12'(q)};
  endfunction

  task automatic clear_src();
    for (int i = 0; i < N; i++) begin
      cnt[i] = 0;
      rd[i]  = 0;
    end
  endtask

  task automatic load_pkt(input int s, input int n);
    for (int w = 0; w < n; w++) begin
      mem[s][cnt[s]] = tagw(s, int'(cnt[s]), w == n - 1);
      cnt[s]++;
    end
  endtask

  function automatic bit all_done();
    for (int i = 0; i < N; i++)
      if (rd[i] != cnt[i]) return 1'b0;
    return 1'b1;
  endfunction

  // One cycle: drive at posedge+1, sample at negedge, advance sources after the edge.
  task automatic step();
    logic [N-1:0] xin;
    logic [16:0]  wd;
    int unsigned  idx;
    for (int i = 0; i < N; i++) begin
      idx = (rd[i] < cnt[i]) ? rd[i] : 0;
      wd  = mem[i][idx];
      c_srdy[i]        = en[i] && (rd[i] < cnt[i]);
      c_data[i*W +: W] = wd[15:0];
      c_eop[i]         = wd[16];
    end
    p_drdy = rnd_drdy ? 1'($urandom_range(0, 1)) : 1'b1;
    @(negedge clk);
    xin     = c_srdy & c_drdy;
    s_drdy  = c_drdy;
    s_grant = p_grant;
    s_psrdy = p_srdy;
    if (!reset && p_srdy && p_drdy) begin
      outq.push_back({p_eop, p_data});
      outcyc.push_back(cyc);
    end
    if (hold_v) check("stall_stable", 32'({p_srdy, p_eop, p_data}), hold_val);
    hold_v   = !reset && p_srdy && !p_drdy;
    hold_val = 32'({p_srdy, p_eop, p_data});
    @(posedge clk);
    #1;
    cyc++;
    for (int i = 0; i < N; i++)
      if (xin[i]) rd[i]++;
  endtask

  task automatic drain(input int unsigned limit);
    int unsigned n;
    n = 0;
    while (!(all_done() && !p_srdy) && n < limit) begin
      step();
      n++;
    end
    check("drain_done", 32'(all_done() && !p_srdy), 32'd1);
  endtask

  task automatic reset_dut();
    reset = 1'b1;
    en    = '0;
    step();
    step();
    reset  = 1'b0;
    hold_v = 1'b0;
    outq.delete();
    outcyc.delete();
  endtask

  initial begin
    int unsigned nx [N];
    int unsigned k;
    int unsigned sum;
    int          cur;
    bit          open;
    logic [16:0] ow;
    logic [16:0] ex;
    int          s;

    reset      = 1'b1;
    c_srdy     = '0;
    c_data     = '0;
    c_eop      = '0;
    p_drdy     = 1'b1;
    cfg_weight = '0;
    en         = '0;
    rnd_drdy   = 1'b0;
    hold_v     = 1'b0;
    hold_val   = '0;
    clear_src();
    @(posedge clk);
    #1;

    // Reset with all inputs requesting, then fair rotation of 1-word packets.
    cfg_weight = {4'd1, 4'd1, 4'd1, 4'd1};
    for (int r = 0; r < 3; r++)
      for (int i = 0; i < N; i++) load_pkt(i, 1);
    en = '1;
    repeat (3) begin
      step();
      check("rst_drdy", 32'(s_drdy), 32'd0);
      check("rst_psrdy", 32'(s_psrdy), 32'd0);
      check("rst_grant", 32'(s_grant), 32'd0);
    end
    reset = 1'b0;
    outq.delete();
    outcyc.delete();
    step();
    check("first_grant", 32'(s_drdy), 32'b0001);
    drain(40);
    check("rot_count", 32'(outq.size()), 32'd12);
    for (int j = 0; j < outq.size(); j++) begin
      check("rot_word", 32'(outq[j]), 32'(tagw(j % 4, j / 4, 1'b1)));
      check("rot_gap", outcyc[j] - outcyc[0], 32'(j));
    end

    // Weights {3,1,0,1}, 2-word packets: 6 words from 0, then 2 each from 1,2,3.
    clear_src();
    reset_dut();
    cfg_weight = {4'd1, 4'd0, 4'd1, 4'd3};
    for (int p = 0; p < 6; p++) load_pkt(0, 2);
    for (int i = 1; i < N; i++) begin
      load_pkt(i, 2);
      load_pkt(i, 2);
    end
    en = '1;
    drain(80);
    check("wt_count", 32'(outq.size()), 32'd24);
    for (int i = 0; i < N; i++) nx[i] = 0;
    k = 0;
    for (int e = 0; e < 12; e++) begin
      s = order[e];
      for (int w = 0; w < 2; w++) begin
        if (k < outq.size()) begin
          check("wt_word", 32'(outq[k]), 32'(tagw(s, int'(nx[s]), w == 1)));
          check("wt_gap", outcyc[k] - outcyc[0], k);
        end
        nx[s]++;
        k++;
      end
    end

    // Packet lock: input 1 stalls mid-packet while input 2 waits.
    clear_src();
    reset_dut();
    cfg_weight = {4'd1, 4'd1, 4'd1, 4'd1};
    load_pkt(1, 3);
    load_pkt(2, 1);
    en = 4'b0010;
    step();
    check("lock_first", 32'(s_drdy), 32'b0010);
    en = 4'b0100;
    repeat (4) begin
      step();
      check("lock_drdy2", 32'(s_drdy[2]), 32'd0);
      check("lock_grant", 32'(s_grant), 32'b0010);
    end
    en = 4'b0110;
    drain(20);
    check("lock_count", 32'(outq.size()), 32'd4);
    if (outq.size() == 4) begin
      check("lock_w0", 32'(outq[0]), 32'(tagw(1, 0, 1'b0)));
      check("lock_w1", 32'(outq[1]), 32'(tagw(1, 1, 1'b0)));
      check("lock_w2", 32'(outq[2]), 32'(tagw(1, 2, 1'b1)));
      check("lock_w3", 32'(outq[3]), 32'(tagw(2, 0, 1'b1)));
    end

    // Backpressure: random p_drdy, three inputs with mixed packet lengths.
    clear_src();
    reset_dut();
    cfg_weight = {4'd1, 4'd1, 4'd1, 4'd2};
    for (int p = 0; p < 6; p++)
      for (int i = 0; i < 3; i++) load_pkt(i, 1 + (p + i) % 3);
    en       = 4'b0111;
    rnd_drdy = 1'b1;
    drain(400);
    rnd_drdy = 1'b0;
    sum = cnt[0] + cnt[1] + cnt[2];
    check("bp_count", 32'(outq.size()), sum);
    for (int i = 0; i < N; i++) nx[i] = 0;
    open = 1'b0;
    cur  = 0;
    for (int j = 0; j < outq.size(); j++) begin
      ow = outq[j];
      s  = int'(ow[15:12]);
      ex = (s < 3 && nx[s] < cnt[s]) ? mem[s][nx[s]] : 17'h1ffff;
      check("bp_word", 32'(ow), 32'(ex));
      if (s < 3) nx[s]++;
      if (open) check("bp_ileave", 32'(s), 32'(cur));
      cur  = s;
      open = !ow[16];
    end

    // Early release at a packet boundary, then reset mid-packet.
    clear_src();
    reset_dut();
    cfg_weight = {4'd1, 4'd4, 4'd1, 4'd1};
    load_pkt(2, 2);
    load_pkt(3, 2);
    en = 4'b1100;
    step();
    check("er_grant2", 32'(s_drdy), 32'b0100);
    step();
    step();
    check("er_own_grant", 32'(s_grant), 32'b0100);
    check("er_drdy3", 32'(s_drdy[3]), 32'd0);
    check("er_idle", 32'(p_grant), 32'd0);
    step();
    check("er_win3", 32'(s_drdy), 32'b1000);
    check("er_own3", 32'(p_grant), 32'b1000);
    reset = 1'b1;
    step();
    check("mr_psrdy", 32'(p_srdy), 32'd0);
    check("mr_grant", 32'(p_grant), 32'd0);
    reset = 1'b0;
    clear_src();
    hold_v = 1'b0;
    outq.delete();
    outcyc.delete();
    load_pkt(1, 1);
    load_pkt(3, 1);
    en = 4'b1010;
    step();
    check("mr_ptr0", 32'(s_drdy), 32'b0010);
    drain(20);
    check("mr_count", 32'(outq.size()), 32'd2);
    if (outq.size() == 2) begin
      check("mr_w0", 32'(outq[0]), 32'(tagw(1, 0, 1'b1)));
      check("mr_w1", 32'(outq[1]), 32'(tagw(3, 0, 1'b1)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
